vz_regfile_sb: RTL and testbench

- Multi-ported, parametrised architectural register file for the VZ16 superscalar core, with an integrated scoreboard (one busy bit per register).
- Replaces the single-mode read/write register file. Reads and writes happen in the same cycle on independent channels.
- Optional write-to-read bypass; per-channel write enables; deterministic same-address write priority.
- Sits between decode/issue (reads, allocation) and writeback (writes, busy clear).

---
 rtl/vz_core_pkg.sv | 11 +
 rtl/vz_wr_prio_match.sv | 27 ++
 rtl/vz_regfile_sb.sv | 130 +++++++++++++
 tb/tb_vz_regfile_sb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vz_core_pkg.sv
// Shared VZ16 core types and register-file sizing constants.
package vz_core_pkg;

    localparam int unsigned VZ_NREG  = 8;
    localparam int unsigned VZ_WIDTH = 16;
    localparam int unsigned VZ_AW    = $clog2(VZ_NREG);

    typedef logic [VZ_AW-1:0]    reg_addr_t;
    typedef logic [VZ_WIDTH-1:0] word_t;

endpackage

// File: rtl/vz_wr_prio_match.sv
// Matches one address against all write channels; highest enabled channel index wins.
module vz_wr_prio_match #(
    parameter int unsigned WCHA  = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
) (
    input  logic [AW-1:0]                addr,
    input  logic [WCHA-1:0]              wr_en,
    input  logic [WCHA-1:0][AW-1:0]      wr_addr,
    input  logic [WCHA-1:0][WIDTH-1:0]   wr_data,
    output logic                         hit,
    output logic [WIDTH-1:0]             data
);

    // Ascending scan so a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned c = 0; c < WCHA; c++) begin
            if (wr_en[c] && (wr_addr[c] == addr)) begin
                hit  = 1'b1;
                data = wr_data[c];
            end
        end
    end

endmodule

// File: rtl/vz_regfile_sb.sv
// Multi-ported VZ16 architectural register file with per-register busy scoreboard.
module vz_regfile_sb
    import vz_core_pkg::*;
#(
    parameter int unsigned NREG   = VZ_NREG,
    parameter int unsigned WIDTH  = VZ_WIDTH,
    parameter int unsigned RCHA   = 4,
    parameter int unsigned WCHA   = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [RCHA-1:0][AW-1:0]      rd_addr,
    output logic [RCHA-1:0][WIDTH-1:0]   rd_data,
    output logic [RCHA-1:0]              rd_busy,
    input  logic [WCHA-1:0]              wr_en,
    input  logic [WCHA-1:0][AW-1:0]      wr_addr,
    input  logic [WCHA-1:0][WIDTH-1:0]   wr_data,
    input  logic [WCHA-1:0]              al_en,
    input  logic [WCHA-1:0][AW-1:0]      al_addr,
    output logic [NREG-1:0]              busy_vec,
    output logic                         err_dbl_alloc,
    output logic                         err_wr_idle
);

    logic [NREG-1:0][WIDTH-1:0] regs_q;
    logic [NREG-1:0]            busy_q;
    logic [NREG-1:0]            busy_d;
    logic                       dbl_alloc_q;
    logic                       wr_idle_q;
    logic                       dbl_alloc_c;
    logic                       wr_idle_c;

    logic [NREG-1:0]            reg_hit;
    logic [NREG-1:0][WIDTH-1:0] reg_wdata;
    logic [RCHA-1:0]            byp_hit;
    logic [RCHA-1:0][WIDTH-1:0] byp_data;

    // Per-register write mux: the same match also drives the busy clear.
    for (genvar i = 0; i < NREG; i++) begin : g_reg_match
        vz_wr_prio_match #(.WCHA(WCHA), .WIDTH(WIDTH), .AW(AW)) u_match (
            .addr    (AW'(i)),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (reg_hit[i]),
            .data    (reg_wdata[i])
        );
    end

    for (genvar r = 0; r < RCHA; r++) begin : g_rd_match
        vz_wr_prio_match #(.WCHA(WCHA), .WIDTH(WIDTH), .AW(AW)) u_match (
            .addr    (rd_addr[r]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (byp_hit[r]),
            .data    (byp_data[r])
        );
    end

    // Read ports: a same-cycle write both forwards its data and hides the busy bit.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned r = 0; r < RCHA; r++) begin
            if ((BYPASS != 0) && byp_hit[r]) begin
                rd_data[r] = byp_data[r];
                rd_busy[r] = 1'b0;
            end else begin
                rd_data[r] = regs_q[rd_addr[r]];
                rd_busy[r] = busy_q[rd_addr[r]];
            end
        end
    end

    // Scoreboard next state: writeback clears first, then allocation sets.
    always_comb begin
        busy_d      = busy_q & ~reg_hit;
        dbl_alloc_c = 1'b0;
        wr_idle_c   = 1'b0;
        for (int unsigned c = 0; c < WCHA; c++) begin
            if (al_en[c]) begin
                busy_d[al_addr[c]] = 1'b1;
                if (busy_q[al_addr[c]] && !reg_hit[al_addr[c]]) begin
                    dbl_alloc_c = 1'b1;
                end
                for (int unsigned d = c + 1; d < WCHA; d++) begin
                    if (al_en[d] && (al_addr[d] == al_addr[c])) begin
                        dbl_alloc_c = 1'b1;
                    end
                end
            end
            if (wr_en[c] && !busy_q[wr_addr[c]]) begin
                wr_idle_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (reg_hit[i]) begin
                    regs_q[i] <= reg_wdata[i];
                end
            end
        end
    end

    // Busy bits and sticky error flags; only reset clears the flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            dbl_alloc_q <= 1'b0;
            wr_idle_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            dbl_alloc_q <= dbl_alloc_q | dbl_alloc_c;
            wr_idle_q   <= wr_idle_q | wr_idle_c;
        end
    end

    assign busy_vec      = busy_q;
    assign err_dbl_alloc = dbl_alloc_q;
    assign err_wr_idle   = wr_idle_q;

endmodule

// File: tb/tb_vz_regfile_sb.sv
// Scoreboard bench for vz_regfile_sb: bypass and non-bypass instances share stimulus.
module tb_vz_regfile_sb;
    import vz_core_pkg::*;

    localparam int unsigned NREG  = VZ_NREG;
    localparam int unsigned WIDTH = VZ_WIDTH;
    localparam int unsigned AW    = VZ_AW;
    localparam int unsigned RCHA  = 4;
    localparam int unsigned WCHA  = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic [RCHA-1:0][AW-1:0]    rd_addr;
    logic [WCHA-1:0]            wr_en;
    logic [WCHA-1:0][AW-1:0]    wr_addr;
    logic [WCHA-1:0][WIDTH-1:0] wr_data;
    logic [WCHA-1:0]            al_en;
    logic [WCHA-1:0][AW-1:0]    al_addr;

    logic [RCHA-1:0][WIDTH-1:0] rd_data_b, rd_data_n;
    logic [RCHA-1:0]            rd_busy_b, rd_busy_n;
    logic [NREG-1:0]            busy_vec_b, busy_vec_n;
    logic                       dbl_b, dbl_n, idle_b, idle_n;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    word_t           m_reg[NREG];
    logic [NREG-1:0] m_busy;
    logic            m_dbl, m_idle;

    always #5 clk = ~clk;

    vz_regfile_sb #(.NREG(NREG), .WIDTH(WIDTH), .RCHA(RCHA), .WCHA(WCHA), .BYPASS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .al_en(al_en), .al_addr(al_addr),
        .busy_vec(busy_vec_b), .err_dbl_alloc(dbl_b), .err_wr_idle(idle_b)
    );

    vz_regfile_sb #(.NREG(NREG), .WIDTH(WIDTH), .RCHA(RCHA), .WCHA(WCHA), .BYPASS(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .al_en(al_en), .al_addr(al_addr),
        .busy_vec(busy_vec_n), .err_dbl_alloc(dbl_n), .err_wr_idle(idle_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    function automatic word_t model_read(input reg_addr_t a, input bit byp);
        word_t v = m_reg[a];
        if (byp) begin
            for (int c = 0; c < WCHA; c++) begin
                if (wr_en[c] && wr_addr[c] == a) v = wr_data[c];
            end
        end
        return v;
    endfunction

    function automatic logic model_rbusy(input reg_addr_t a, input bit byp);
        logic b = m_busy[a];
        if (byp) begin
            for (int c = 0; c < WCHA; c++) begin
                if (wr_en[c] && wr_addr[c] == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_busy = '0;
        m_dbl  = 1'b0;
        m_idle = 1'b0;
    endtask

    // Reference next state from the current inputs, applied at the clock edge.
    task automatic model_step();
        word_t           nreg[NREG];
        logic [NREG-1:0] clr, nbusy;
        for (int i = 0; i < NREG; i++) nreg[i] = m_reg[i];
        clr = '0;
        for (int c = 0; c < WCHA; c++) begin
            if (wr_en[c]) begin
                nreg[wr_addr[c]] = wr_data[c];
                clr[wr_addr[c]]  = 1'b1;
                if (!m_busy[wr_addr[c]]) m_idle = 1'b1;
            end
        end
        nbusy = m_busy & ~clr;
        for (int c = 0; c < WCHA; c++) begin
            if (al_en[c]) begin
                nbusy[al_addr[c]] = 1'b1;
                if (m_busy[al_addr[c]] && !clr[al_addr[c]]) m_dbl = 1'b1;
                for (int d = 0; d < WCHA; d++) begin
                    if (d != c && al_en[d] && al_addr[d] == al_addr[c]) m_dbl = 1'b1;
                end
            end
        end
        for (int i = 0; i < NREG; i++) m_reg[i] = nreg[i];
        m_busy = nbusy;
    endtask

    task automatic idle_inputs();
        wr_en = '0;
        al_en = '0;
    endtask

    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic run_cycle();
        #1;
        for (int r = 0; r < RCHA; r++) begin
            exp_q.push_back(32'(model_read(rd_addr[r], 1'b1)));
            exp_q.push_back(32'(model_rbusy(rd_addr[r], 1'b1)));
            exp_q.push_back(32'(model_read(rd_addr[r], 1'b0)));
            exp_q.push_back(32'(model_rbusy(rd_addr[r], 1'b0)));
        end
        for (int r = 0; r < RCHA; r++) begin
            chk_pop("rd_data_byp", 32'(rd_data_b[r]));
            chk_pop("rd_busy_byp", 32'(rd_busy_b[r]));
            chk_pop("rd_data_nobyp", 32'(rd_data_n[r]));
            chk_pop("rd_busy_nobyp", 32'(rd_busy_n[r]));
        end
        model_step();
        @(posedge clk);
        #1;
        exp_q.push_back(32'(m_busy));
        exp_q.push_back(32'(m_dbl));
        exp_q.push_back(32'(m_idle));
        exp_q.push_back(32'(m_busy));
        chk_pop("busy_vec", 32'(busy_vec_b));
        chk_pop("err_dbl_alloc", 32'(dbl_b));
        chk_pop("err_wr_idle", 32'(idle_b));
        chk_pop("busy_vec_nobyp", 32'(busy_vec_n));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        al_addr = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        chk("rst_busy_vec", 32'(busy_vec_b), 32'h0);
        chk("rst_err_dbl", 32'(dbl_b), 32'h0);
        chk("rst_err_idle", 32'(idle_b), 32'h0);
        for (int a = 0; a < NREG; a++) begin
            for (int r = 0; r < RCHA; r++) rd_addr[r] = AW'(a);
            run_cycle();
        end

        // Same-address dual write: channel 1 wins, bypass forwards it.
        wr_en = 2'b11;
        wr_addr[0] = 3'd3; wr_addr[1] = 3'd3;
        wr_data[0] = 16'h1234; wr_data[1] = 16'hBEEF;
        rd_addr[0] = 3'd3;
        #1;
        chk("byp_same_cycle", 32'(rd_data_b[0]), 32'hBEEF);
        chk("nobyp_same_cycle", 32'(rd_data_n[0]), 32'h0);
        run_cycle();
        idle_inputs();
        #1;
        chk("byp_next_cycle", 32'(rd_data_b[0]), 32'hBEEF);
        chk("nobyp_next_cycle", 32'(rd_data_n[0]), 32'hBEEF);
        run_cycle();

        do_reset();

        al_en = 2'b01; al_addr[0] = 3'd5;
        run_cycle();
        idle_inputs();
        rd_addr[1] = 3'd5;
        #1;
        chk("alloc5_busy_vec", 32'(busy_vec_b[5]), 32'h1);
        chk("alloc5_rd_busy", 32'(rd_busy_b[1]), 32'h1);
        run_cycle();
        wr_en = 2'b10; wr_addr[1] = 3'd5; wr_data[1] = 16'h00A5;
        #1;
        chk("wb5_rd_busy", 32'(rd_busy_b[1]), 32'h0);
        chk("wb5_rd_data", 32'(rd_data_b[1]), 32'h00A5);
        chk("wb5_rd_busy_nobyp", 32'(rd_busy_n[1]), 32'h1);
        run_cycle();
        chk("wb5_busy_clear", 32'(busy_vec_b[5]), 32'h0);

        al_en = 2'b01; al_addr[0] = 3'd2; wr_en = '0;
        run_cycle();
        idle_inputs();
        wr_en = 2'b01; wr_addr[0] = 3'd2; wr_data[0] = 16'h2222;
        al_en = 2'b10; al_addr[1] = 3'd2;
        run_cycle();
        chk("realloc2_busy", 32'(busy_vec_b[2]), 32'h1);
        chk("realloc2_no_dbl", 32'(dbl_b), 32'h0);
        chk("realloc2_no_idle", 32'(idle_b), 32'h0);
        idle_inputs();
        rd_addr[2] = 3'd2;
        #1;
        chk("realloc2_data", 32'(rd_data_b[2]), 32'h2222);
        run_cycle();

        al_en = 2'b11; al_addr[0] = 3'd6; al_addr[1] = 3'd6;
        run_cycle();
        chk("dual_alloc_err", 32'(dbl_b), 32'h1);
        idle_inputs();
        wr_en = 2'b01; wr_addr[0] = 3'd7; wr_data[0] = 16'h0777;
        run_cycle();
        chk("idle_wr_err", 32'(idle_b), 32'h1);
        idle_inputs();
        rd_addr[3] = 3'd7;
        repeat (3) run_cycle();
        chk("idle_wr_data", 32'(rd_data_b[3]), 32'h0777);
        chk("dbl_sticky", 32'(dbl_b), 32'h1);
        chk("idle_sticky", 32'(idle_b), 32'h1);

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            for (int r = 0; r < RCHA; r++) rd_addr[r] = AW'($urandom);
            for (int c = 0; c < WCHA; c++) begin
                wr_en[c]   = ($urandom_range(0, 2) == 0);
                wr_addr[c] = AW'($urandom);
                wr_data[c] = WIDTH'($urandom);
                al_en[c]   = ($urandom_range(0, 3) == 0);
                al_addr[c] = AW'($urandom);
            end
            if (n % 8 == 0 && wr_en[0]) begin
                wr_addr[1] = wr_addr[0];
                wr_en[1]   = 1'b1;
            end
            if (n % 5 == 0) rd_addr[0] = wr_addr[WCHA-1];
            run_cycle();
        end

        // Asynchronous reset between edges in the middle of a write/alloc bundle.
        wr_en = 2'b11; wr_addr[0] = 3'd4; wr_addr[1] = 3'd1;
        wr_data[0] = 16'h4444; wr_data[1] = 16'h1111;
        al_en = 2'b11; al_addr[0] = 3'd0; al_addr[1] = 3'd0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_busy_vec", 32'(busy_vec_b), 32'h0);
        chk("async_rst_err_dbl", 32'(dbl_b), 32'h0);
        chk("async_rst_err_idle", 32'(idle_b), 32'h0);
        idle_inputs();
        for (int a = 0; a < NREG; a++) begin
            rd_addr[0] = AW'(a);
            #1;
            chk("async_rst_rd_data", 32'(rd_data_b[0]), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy_vec", 32'(busy_vec_b), 32'h0);
        wr_en = 2'b01; wr_addr[0] = 3'd1; wr_data[0] = 16'h7FFF;
        run_cycle();
        idle_inputs();
        rd_addr[0] = 3'd1;
        #1;
        chk("post_rst_write", 32'(rd_data_b[0]), 32'h7FFF);
        run_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
